// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges pipeline and long-latency writebacks onto one RF write port with a busy scoreboard and starvation hold
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        sb_set,
    input  logic [4:0]  sb_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        hold_pipe,
    output logic        waw_err
);
    typedef enum logic {RUN, HOLD} state_t;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        waw_err_q, waw_err_d;
    logic        a_act;

    always_comb begin
        a_act    = a_valid && (a_rd != 5'd0);
        b_ready  = b_valid && !a_act;
        rf_we    = a_act || b_ready;
        rf_rd    = a_act ? a_rd : (b_ready ? b_rd : 5'd0);
        rf_wdata = a_act ? a_data : (b_ready ? b_data : 32'd0);
        rs1_busy = busy_q[rs1];
        rs2_busy = busy_q[rs2];
        // set is applied after clear so a same-index collision leaves the entry busy
        busy_d = busy_q;
        if (b_ready) busy_d[b_rd] = 1'b0;
        if (sb_set) busy_d[sb_rd] = 1'b1;
        busy_d[0] = 1'b0;
        cnt_d   = (!b_valid || b_ready) ? 4'd0 : ((cnt_q == LIM) ? cnt_q : cnt_q + 4'd1);
        state_d = (state_q == RUN) ? ((cnt_d == LIM) ? HOLD : RUN) : (b_ready ? RUN : HOLD);
        waw_err_d = waw_err_q
                  || (a_act && busy_q[a_rd])
                  || (sb_set && (sb_rd != 5'd0) && busy_q[sb_rd] && !(b_ready && (b_rd == sb_rd)))
                  || (a_valid && (state_q == HOLD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            busy_q    <= 32'd0;
            cnt_q     <= 4'd0;
            waw_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            waw_err_q <= waw_err_d;
        end
    end

    assign hold_pipe = (state_q == HOLD);
    assign waw_err   = waw_err_q;
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter and scoreboard for the 32x32 integer register file. It merges the in-order pipeline writeback (port A) and a long-latency functional unit, such as mul/div (port B), onto the register file's single write port. It tracks destination registers with outstanding long-latency results and reports source-operand hazards to the issue stage. It asserts a pipeline hold when port B has been starved.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive cycles port B may wait with b_valid=1 before hold_pipe asserts. Legal range is 1-15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_valid  in  1  pipeline writeback valid; port A is never back-pressured
- a_rd  in  5  port A destination
- a_data  in  32  port A write data
- b_valid  in  1  long-latency result valid; held with its rd/data stable until b_ready
- b_rd  in  5  port B destination
- b_data  in  32  port B write data
- b_ready  out  1  port B accepted this cycle
- sb_set  in  1  issue stage dispatches a long-latency op
- sb_rd  in  5  destination of the dispatched op
- rs1, rs2  in  5 each  issue-stage source register indices
- rs1_busy, rs2_busy  out  1 each  source has a pending long-latency write
- rf_we  out  1  to register file reg_write
- rf_rd  out  5  to register file rd
- rf_wdata  out  32  to register file write_data
- hold_pipe  out  1  registered request to bubble port A
- waw_err  out  1  sticky protocol-violation flag

## Operation
- A_act = a_valid && a_rd!=0; B_act = b_valid.
- Grant: A_act has priority. b_ready = B_act && !A_act. b_ready is combinational, with zero cycles from b_valid to write.
- rf_we = A_act || b_ready; rf_rd/rf_wdata are a_rd/a_data when A_act, otherwise b_rd/b_data. When rf_we=0, rf_rd=0 and rf_wdata=0.
- A write with a_rd=0 is a no-op and does not block B. A B write with b_rd=0 is accepted and rf_we=1 with rd 0; the register file discards it.
- Scoreboard: a 32-bit busy register.
  - sb_set with sb_rd!=0 sets busy[sb_rd].
  - b_ready clears busy[b_rd].
  - If set and clear hit the same index in the same cycle, set wins.
  - busy[0] is always 0.
- rs1_busy = busy[rs1] and rs2_busy = busy[rs2]. Both are combinational from the registered busy vector, so a clear takes effect the cycle after b_ready. The register file is written on that same edge, so there is no forwarding gap.
- Starve counter, saturating at STARVE_LIMIT:
  - Increments each cycle B_act && !b_ready.
  - Clears to 0 on b_ready or when !b_valid.
- hold_pipe FSM:
  - RUN to HOLD when the counter will equal STARVE_LIMIT at the next edge.
  - HOLD to RUN on the edge after b_ready.
  - hold_pipe=1 in HOLD.
  - Contract: the pipeline drives a_valid=0 in every cycle where hold_pipe=1, so B is granted in the first HOLD cycle.
- waw_err is set and then stays 1 until rst when any of these occurs:
  - A_act while busy[a_rd]=1;
  - sb_set with sb_rd!=0 while busy[sb_rd]=1 and the cycle is not clearing that same index;
  - a_valid=1 while hold_pipe=1.

## Timing
- Reset, asynchronous: busy=0, counter=0, FSM=RUN. All outputs are 0 at reset: hold_pipe=0, waw_err=0, and with inputs idle b_ready=0, rf_we=0, rf_rd=0, rf_wdata=0, rs1_busy=0, rs2_busy=0.
- Reset asserted mid-operation discards pending scoreboard state. A B request still held after reset is granted normally.
- Write latency is 0 cycles: the register file captures on the same clk edge the grant is made.
- Maximum B wait with a compliant pipeline is STARVE_LIMIT+1 cycles from b_valid rising to b_ready.
- All state updates on posedge clk. Outputs other than hold_pipe and waw_err are combinational from inputs and state.

## Test plan
- Reset, then sb_set rd=5 and check rs1=5 gives rs1_busy=1 next cycle. Then b_valid rd=5 data=0xDEADBEEF with a_valid=0 gives b_ready=1, rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, and rs1_busy=0 the following cycle.
- Conflict: a_valid rd=3 and b_valid rd=7 in the same cycle. rf_rd=3 and b_ready=0. Next cycle with a_valid=0 gives rf_rd=7 and b_ready=1.
- a_valid with a_rd=0 and b_valid rd=9 in the same cycle: b_ready=1 and rf_rd=9 in that cycle.
- Starvation with STARVE_LIMIT=4: a_valid=1 (rd=1) every cycle, b_valid held. hold_pipe rises after 4 blocked cycles. Drop a_valid: b_ready=1 in the first HOLD cycle, and hold_pipe=0 the cycle after.
- In the same cycle, sb_set rd=12 and b_ready with b_rd=12: busy[12] stays 1 and waw_err stays 0.
- A_act to a busy rd=12, sb_set to an already-busy rd, and a_valid during hold_pipe=1 (separate runs): each sets waw_err=1, which stays 1 until rst.
